// File: rtl/mem_stage_pipe_pkg.sv
// Shared types and helpers for the MEM stage: default widths, access FSM encoding and
// byte-address to word-index conversion.
package mem_stage_pipe_pkg;

  localparam int unsigned REGISTER_LEN    = 32;
  localparam int unsigned REG_ADDRESS_LEN = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Caller truncates the result to the memory index width.
  function automatic logic [REGISTER_LEN-1:0] addr_to_index(
    input logic [REGISTER_LEN-1:0] addr,
    input logic [REGISTER_LEN-1:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// EXE/MEM -> MEM stage -> MEM/WB bundle. The master is the upstream pipeline, the slave is the
// MEM stage. misalign_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_stage_pipe_if
  import mem_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = REGISTER_LEN,
  parameter int unsigned REG_ADDR_W = REG_ADDRESS_LEN
);

  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic [DATA_W-1:0]     alu_res_in;
  logic [DATA_W-1:0]     val_rm_in;
  logic [REG_ADDR_W-1:0] dest_in;

  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic [DATA_W-1:0]     alu_res_out;
  logic [DATA_W-1:0]     mem_res_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic                  wb_en_hazard_out;
  logic [REG_ADDR_W-1:0] dest_hazard_out;
  logic                  mem_freeze;
`ifdef MEM_ALIGN_CHECK_EN
  logic                  misalign_err;
`endif

  modport master (
`ifdef MEM_ALIGN_CHECK_EN
    input  misalign_err,
`endif
    output wb_en_in,
    output mem_r_en_in,
    output mem_w_en_in,
    output alu_res_in,
    output val_rm_in,
    output dest_in,
    input  wb_en_out,
    input  mem_r_en_out,
    input  alu_res_out,
    input  mem_res_out,
    input  dest_out,
    input  wb_en_hazard_out,
    input  dest_hazard_out,
    input  mem_freeze
  );

  modport slave (
`ifdef MEM_ALIGN_CHECK_EN
    output misalign_err,
`endif
    input  wb_en_in,
    input  mem_r_en_in,
    input  mem_w_en_in,
    input  alu_res_in,
    input  val_rm_in,
    input  dest_in,
    output wb_en_out,
    output mem_r_en_out,
    output alu_res_out,
    output mem_res_out,
    output dest_out,
    output wb_en_hazard_out,
    output dest_hazard_out,
    output mem_freeze
  );

endinterface

// File: rtl/mem_stage_dmem.sv
// Word-addressed data memory: synchronous write, asynchronous read. Contents are not reset.
module mem_stage_dmem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage with internal data memory, WAIT_CYC wait states, MEM/WB register and hazard taps.
// Define MEM_ALIGN_CHECK_EN to add misalign_err and drop misaligned accesses.
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = REGISTER_LEN,
  parameter int unsigned REG_ADDR_W = REG_ADDRESS_LEN,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_BASE  = 1024,
  parameter int unsigned WAIT_CYC   = 0
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_pipe_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [DATA_W:0] AddrLo = (DATA_W + 1)'(ADDR_BASE);
  localparam logic [DATA_W:0] AddrHi = (DATA_W + 1)'(ADDR_BASE + 4 * DEPTH);

  logic              access;
  logic              in_range;
  logic              addr_ok;
  logic [IdxW-1:0]   idx;
  logic [DATA_W-1:0] rdata;
  logic              freeze;
  logic              complete;
  logic              we;

  assign access = bus.mem_r_en_in | bus.mem_w_en_in;

  // One extra bit so ADDR_BASE + 4*DEPTH cannot wrap at the top of the address space.
  assign in_range = ({1'b0, bus.alu_res_in} >= AddrLo) && ({1'b0, bus.alu_res_in} < AddrHi);
  assign idx = IdxW'(addr_to_index(REGISTER_LEN'(bus.alu_res_in), REGISTER_LEN'(ADDR_BASE)));

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |bus.alu_res_in[1:0];
  assign addr_ok    = in_range & ~misaligned;
`else
  assign addr_ok    = in_range;
`endif

  // Access timing: single-cycle, or an IDLE/BUSY sequence of WAIT_CYC+1 cycles.
  if (WAIT_CYC == 0) begin : g_single
    assign freeze   = 1'b0;
    assign complete = access;
  end else begin : g_wait
    localparam int unsigned CntW = $clog2(WAIT_CYC + 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            last_q;

    assign last_q = (cnt_q == CntW'(WAIT_CYC));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (access) begin
              state_q <= ST_BUSY;
              cnt_q   <= CntW'(1);
            end
          end
          ST_BUSY: begin
            if (last_q) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    // Gated by rst so an abandoned access releases the stall while reset is still low.
    assign freeze   = rst & (((state_q == ST_IDLE) & access) | ((state_q == ST_BUSY) & ~last_q));
    assign complete = (state_q == ST_BUSY) & last_q;
  end

  assign we = rst & complete & bus.mem_w_en_in & addr_ok;

  mem_stage_dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .idx   (idx),
    .wdata (bus.val_rm_in),
    .rdata (rdata)
  );

  // MEM/WB register
  logic                  wb_en_q;
  logic                  mem_r_en_q;
  logic [DATA_W-1:0]     alu_res_q;
  logic [DATA_W-1:0]     mem_res_q;
  logic [DATA_W-1:0]     mem_res_d;
  logic [REG_ADDR_W-1:0] dest_q;

  assign mem_res_d = (bus.mem_r_en_in & addr_ok) ? rdata : '0;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= ~freeze & access & misaligned;
    end
  end

  assign bus.misalign_err = misalign_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_res_q  <= '0;
      dest_q     <= '0;
    end else if (freeze) begin
      // Bubble into WB; data fields hold.
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else begin
      wb_en_q    <= bus.wb_en_in;
      mem_r_en_q <= bus.mem_r_en_in;
      alu_res_q  <= bus.alu_res_in;
      mem_res_q  <= mem_res_d;
      dest_q     <= bus.dest_in;
    end
  end

  assign bus.wb_en_out        = wb_en_q;
  assign bus.mem_r_en_out     = mem_r_en_q;
  assign bus.alu_res_out      = alu_res_q;
  assign bus.mem_res_out      = mem_res_q;
  assign bus.dest_out         = dest_q;
  assign bus.wb_en_hazard_out = bus.wb_en_in;
  assign bus.dest_hazard_out  = bus.dest_in;
  assign bus.mem_freeze       = freeze;

  a_no_dual_access : assert property (@(posedge clk) disable iff (!rst)
    !(bus.mem_r_en_in && bus.mem_w_en_in));

  a_stable_in_freeze : assert property (@(posedge clk) disable iff (!rst)
    freeze |=> $stable({bus.mem_r_en_in, bus.mem_w_en_in, bus.alu_res_in, bus.val_rm_in,
                        bus.dest_in}));

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: three instances with WAIT_CYC = 0, 2 and 3 share clock/reset.
module tb_mem_stage_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb;
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  dest;
  } stim_t;

  stim_t s0 = '0;
  stim_t s2 = '0;
  stim_t s3 = '0;

  mem_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(4)) b0 ();
  mem_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(4)) b2 ();
  mem_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(4)) b3 ();

  assign b0.wb_en_in = s0.wb;  assign b0.mem_r_en_in = s0.r;  assign b0.mem_w_en_in = s0.w;
  assign b0.alu_res_in = s0.addr;  assign b0.val_rm_in = s0.data;  assign b0.dest_in = s0.dest;
  assign b2.wb_en_in = s2.wb;  assign b2.mem_r_en_in = s2.r;  assign b2.mem_w_en_in = s2.w;
  assign b2.alu_res_in = s2.addr;  assign b2.val_rm_in = s2.data;  assign b2.dest_in = s2.dest;
  assign b3.wb_en_in = s3.wb;  assign b3.mem_r_en_in = s3.r;  assign b3.mem_w_en_in = s3.w;
  assign b3.alu_res_in = s3.addr;  assign b3.val_rm_in = s3.data;  assign b3.dest_in = s3.dest;

  mem_stage_pipe #(.WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst_n), .bus(b0));
  mem_stage_pipe #(.WAIT_CYC(2)) dut2 (.clk(clk), .rst(rst_n), .bus(b2));
  mem_stage_pipe #(.WAIT_CYC(3)) dut3 (.clk(clk), .rst(rst_n), .bus(b3));

  function automatic stim_t st(input logic [31:0] a, input logic [31:0] d);
    stim_t s;
    s = '0;  s.w = 1'b1;  s.addr = a;  s.data = d;
    return s;
  endfunction

  function automatic stim_t ld(input logic [31:0] a, input logic [3:0] dst);
    stim_t s;
    s = '0;  s.wb = 1'b1;  s.r = 1'b1;  s.addr = a;  s.dest = dst;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc0(input stim_t s);
    s0 = s;  step();  s0 = '0;
  endtask

  task automatic acc2(input stim_t s);
    s2 = s;  repeat (3) step();  s2 = '0;
  endtask

  task automatic acc3(input stim_t s);
    s3 = s;  repeat (4) step();  s3 = '0;
  endtask

  task automatic test_reset();
    s0 = '0;  s0.wb = 1'b1;  s0.dest = 4'd9;
    #2;
    total++;
    if ({b0.wb_en_out, b0.mem_r_en_out, b0.alu_res_out, b0.mem_res_out, b0.dest_out,
         b0.mem_freeze} !== '0)
      $display("FAIL reset_dut0: outputs=%h required 0", {b0.wb_en_out, b0.mem_r_en_out,
               b0.alu_res_out, b0.mem_res_out, b0.dest_out, b0.mem_freeze});
    else passed++;
    total++;
    if ({b3.wb_en_out, b3.mem_r_en_out, b3.alu_res_out, b3.mem_res_out, b3.dest_out,
         b3.mem_freeze} !== '0)
      $display("FAIL reset_dut3: outputs=%h required 0", {b3.wb_en_out, b3.mem_r_en_out,
               b3.alu_res_out, b3.mem_res_out, b3.dest_out, b3.mem_freeze});
    else passed++;
    total++;
    if ({b0.wb_en_hazard_out, b0.dest_hazard_out} !== 5'h19)
      $display("FAIL hazard_taps: got %h required 19", {b0.wb_en_hazard_out, b0.dest_hazard_out});
    else passed++;
    s0 = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_busy();
    acc3(st(32'd1040, 32'h55AA55AA));
    s3 = st(32'd1040, 32'h12345678);
    step();
    step();
    total++;
    if (b3.mem_freeze !== 1'b1) $display("FAIL busy_freeze: got %b required 1", b3.mem_freeze);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (b3.mem_freeze !== 1'b0) $display("FAIL rst_freeze: got %b required 0", b3.mem_freeze);
    else passed++;
    total++;
    if ({b3.wb_en_out, b3.mem_r_en_out, b3.alu_res_out, b3.mem_res_out, b3.dest_out} !== '0)
      $display("FAIL rst_outputs: got %h required 0", {b3.wb_en_out, b3.mem_r_en_out,
               b3.alu_res_out, b3.mem_res_out, b3.dest_out});
    else passed++;
    step();
    s3 = '0;
    rst_n = 1'b1;
    step();
    acc3(ld(32'd1040, 4'd2));
    total++;
    if (b3.mem_res_out !== 32'h55AA55AA)
      $display("FAIL rst_no_store: got %h required 55aa55aa", b3.mem_res_out);
    else passed++;
  endtask

  task automatic test_single_cycle();
    s0 = st(32'd1028, 32'hDEADBEEF);
    #1;
    total++;
    if (b0.mem_freeze !== 1'b0) $display("FAIL sc_store_freeze: got %b required 0", b0.mem_freeze);
    else passed++;
    step();
    s0 = ld(32'd1028, 4'd5);
    #1;
    total++;
    if (b0.mem_freeze !== 1'b0) $display("FAIL sc_load_freeze: got %b required 0", b0.mem_freeze);
    else passed++;
    step();
    total++;
    if ({b0.mem_res_out, b0.mem_r_en_out, b0.dest_out, b0.wb_en_out} !== {32'hDEADBEEF, 1'b1,
        4'd5, 1'b1})
      $display("FAIL sc_load: got %h required deadbeefb", {b0.mem_res_out, b0.mem_r_en_out,
               b0.dest_out, b0.wb_en_out});
    else passed++;
    s0 = '0;
  endtask

  task automatic test_passthrough();
    s3 = '0;  s3.wb = 1'b1;  s3.addr = 32'h1234;  s3.dest = 4'd3;
    #1;
    total++;
    if (b3.mem_freeze !== 1'b0) $display("FAIL pt_freeze: got %b required 0", b3.mem_freeze);
    else passed++;
    step();
    total++;
    if ({b3.alu_res_out, b3.wb_en_out, b3.mem_r_en_out, b3.dest_out} !== {32'h1234, 1'b1, 1'b0,
        4'd3})
      $display("FAIL passthrough: got %h required 0000123423", {b3.alu_res_out, b3.wb_en_out,
               b3.mem_r_en_out, b3.dest_out});
    else passed++;
    s3 = '0;
    step();
  endtask

  task automatic test_wait_load();
    int highs;
    highs = 0;
    acc3(st(32'd1024, 32'hCAFEF00D));
    s3 = ld(32'd1024, 4'd7);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (b3.mem_freeze === 1'b1) highs++;
      total++;
      if (b3.mem_freeze !== (k < 3))
        $display("FAIL wl_freeze_%0d: got %b required %b", k, b3.mem_freeze, (k < 3));
      else passed++;
      if (k == 1) begin
        total++;
        if ({b3.wb_en_hazard_out, b3.dest_hazard_out} !== 5'h17)
          $display("FAIL wl_hazard: got %h required 17", {b3.wb_en_hazard_out, b3.dest_hazard_out});
        else passed++;
      end
      step();
      if (k < 3) begin
        total++;
        if ({b3.wb_en_out, b3.mem_r_en_out} !== 2'b00)
          $display("FAIL wl_bubble_%0d: got %b required 00", k, {b3.wb_en_out, b3.mem_r_en_out});
        else passed++;
      end
    end
    total++;
    if (highs != 3) $display("FAIL wl_freeze_count: got %0d required 3", highs);
    else passed++;
    total++;
    if ({b3.mem_res_out, b3.wb_en_out, b3.mem_r_en_out, b3.dest_out} !== {32'hCAFEF00D, 1'b1,
        1'b1, 4'd7})
      $display("FAIL wl_data: got %h required cafef00d37", {b3.mem_res_out, b3.wb_en_out,
               b3.mem_r_en_out, b3.dest_out});
    else passed++;
    s3 = '0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = 6'b011011;
    s2 = st(32'd1032, 32'h11);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        s2 = st(32'd1036, 32'h22);
        #1;
      end
      total++;
      if (b2.mem_freeze !== pat[k])
        $display("FAIL b2b_freeze_%0d: got %b required %b", k, b2.mem_freeze, pat[k]);
      else passed++;
      step();
    end
    s2 = '0;
    acc2(ld(32'd1032, 4'd1));
    total++;
    if (b2.mem_res_out !== 32'h11) $display("FAIL b2b_load0: got %h required 11", b2.mem_res_out);
    else passed++;
    acc2(ld(32'd1036, 4'd2));
    total++;
    if (b2.mem_res_out !== 32'h22) $display("FAIL b2b_load1: got %h required 22", b2.mem_res_out);
    else passed++;
  endtask

  task automatic test_out_of_range();
    acc0(st(32'd1024, 32'hA0));
    acc0(st(32'd1276, 32'hA63));
    acc0(st(32'd1020, 32'h99));
    acc0(st(32'd1280, 32'h98));
    acc0(ld(32'd1020, 4'd1));
    total++;
    if ({b0.mem_res_out, b0.mem_r_en_out} !== {32'h0, 1'b1})
      $display("FAIL oor_load_low: got %h required 1", {b0.mem_res_out, b0.mem_r_en_out});
    else passed++;
    acc0(ld(32'd1280, 4'd1));
    total++;
    if (b0.mem_res_out !== 32'h0) $display("FAIL oor_load_high: got %h required 0", b0.mem_res_out);
    else passed++;
    acc0(ld(32'd1024, 4'd1));
    total++;
    if (b0.mem_res_out !== 32'hA0) $display("FAIL oor_word0: got %h required a0", b0.mem_res_out);
    else passed++;
    acc0(ld(32'd1276, 4'd1));
    total++;
    if (b0.mem_res_out !== 32'hA63)
      $display("FAIL oor_word63: got %h required a63", b0.mem_res_out);
    else passed++;
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    acc0(st(32'd1024, 32'h77));
    total++;
    if (b0.misalign_err !== 1'b0) $display("FAIL ma_aligned: got %b required 0", b0.misalign_err);
    else passed++;
    acc0(st(32'd1025, 32'hBAD));
    total++;
    if (b0.misalign_err !== 1'b1) $display("FAIL ma_store: got %b required 1", b0.misalign_err);
    else passed++;
    step();
    total++;
    if (b0.misalign_err !== 1'b0) $display("FAIL ma_pulse: got %b required 0", b0.misalign_err);
    else passed++;
    acc0(ld(32'd1025, 4'd1));
    total++;
    if ({b0.mem_res_out, b0.misalign_err} !== {32'h0, 1'b1})
      $display("FAIL ma_load: got %h required 1", {b0.mem_res_out, b0.misalign_err});
    else passed++;
    acc0(ld(32'd1024, 4'd1));
    total++;
    if (b0.mem_res_out !== 32'h77) $display("FAIL ma_word0: got %h required 77", b0.mem_res_out);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid_busy();
    test_single_cycle();
    test_passthrough();
    test_wait_load();
    test_back_to_back();
    test_out_of_range();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
